// File: rtl/serial_subtractor_4bit_pkg.sv
// ============================================================================
// serial_subtractor_4bit_pkg : shared width default and FSM state encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_subtractor_4bit_pkg;

  localparam int C_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_4bit_bit_cell.sv
// ============================================================================
// sub_bit_cell : one-bit full-adder slice used for a + ~b + 1, LSB first
// Rev 1.0
// ============================================================================
`default_nettype none

module sub_bit_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

`default_nettype wire

// File: rtl/serial_subtractor_4bit.sv
// ============================================================================
// serial_subtractor_4bit : bit-serial two's complement a - b, one bit per clock
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_subtractor_4bit
  import serial_subtractor_4bit_pkg::*;
#(
  parameter int WIDTH = C_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             carryout,
  output logic             overflow
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-2:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             carryout_q, carryout_d;
  logic             overflow_q, overflow_d;

  logic             cell_s;
  logic             cell_cout;

  sub_bit_cell u_cell (
    .x    (a_q[0]),
    .y    (nb_q[0]),
    .cin  (carry_q),
    .s    (cell_s),
    .cout (cell_cout)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    nb_d       = nb_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    diff_d     = diff_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          nb_d    = ~b;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_d     = a_q >> 1;
        nb_d    = nb_q >> 1;
        sum_d   = {cell_s, sum_q[WIDTH-2:1]};
        carry_d = cell_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // carry_q here is the carry into the MSB; results publish all at once
          diff_d     = {cell_s, sum_q};
          carryout_d = cell_cout;
          overflow_d = carry_q ^ cell_cout;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      nb_q       <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      diff_q     <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      nb_q       <= nb_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      diff_q     <= diff_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == ST_SHIFT);
  assign done     = (state_q == ST_DONE);
  assign diff     = diff_q;
  assign carryout = carryout_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor_4bit.sv
// ============================================================================
// tb_serial_subtractor_4bit : directed and random checks of the serial subtractor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor_4bit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       carryout;
  logic       overflow;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] hold_diff;
  logic       hold_co;
  logic       hold_ov;

  serial_subtractor_4bit #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .carryout (carryout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the signed/unsigned interpretations.
  function automatic void model(input logic [3:0] x, input logic [3:0] y,
                                output logic [3:0] d, output logic co, output logic ov);
    int ux, uy, sx, sy, r;
    ux = int'(x);
    uy = int'(y);
    sx = (ux > 7) ? ux - 16 : ux;
    sy = (uy > 7) ? uy - 16 : uy;
    r  = sx - sy;
    d  = 4'((ux - uy + 16) % 16);
    co = (ux >= uy);
    ov = (r > 7) || (r < -8);
  endfunction

  task automatic check_hold(input string tag);
    check({tag, "_diff"}, 32'(diff), 32'(hold_diff));
    check({tag, "_co"},   32'(carryout), 32'(hold_co));
    check({tag, "_ov"},   32'(overflow), 32'(hold_ov));
  endtask

  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_, input bit rel_rst);
    logic [3:0] ed;
    logic       eco, eov;
    model(ta, tb_, ed, eco, eov);
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    if (rel_rst) reset = 1'b0;
    @(negedge clk);
    start = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);
    for (int i = 1; i <= 4; i++) begin
      check("busy_shift", 32'(busy), 32'd1);
      check("done_shift", 32'(done), 32'd0);
      check_hold("hold_shift");
      if (i < 4) @(negedge clk);
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done",  32'(busy), 32'd0);
    check("diff",       32'(diff), 32'(ed));
    check("carryout",   32'(carryout), 32'(eco));
    check("overflow",   32'(overflow), 32'(eov));
    hold_diff = ed; hold_co = eco; hold_ov = eov;
    @(negedge clk);
    check("done_after", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check_hold("hold_idle");
  endtask

  initial begin
    int nd, first, second;
    logic [3:0] ed;
    logic       eco, eov;

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    hold_diff = '0; hold_co = 1'b0; hold_ov = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_hold("rst");
    reset = 1'b0;

    run_op(4'b0101, 4'b0011, 1'b0);
    run_op(4'b0111, 4'b1111, 1'b0);
    run_op(4'b1000, 4'b0001, 1'b0);
    run_op(4'b0000, 4'b0000, 1'b0);

    // Start requests during SHIFT must be discarded
    @(negedge clk);
    a = 4'b0001; b = 4'b0001; start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      a = 4'b1111; b = 4'b0000; start = 1'b1;
      check("ign_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    start = 1'b0;
    check("ign_done", 32'(done), 32'd1);
    check("ign_diff", 32'(diff), 32'h0);
    check("ign_co",   32'(carryout), 32'd1);
    check("ign_ov",   32'(overflow), 32'd0);
    hold_diff = 4'h0; hold_co = 1'b1; hold_ov = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("ign_nodone", 32'(done), 32'd0);
      check("ign_nobusy", 32'(busy), 32'd0);
    end

    run_op(4'b0101, 4'b0011, 1'b0);

    // Reset in the second SHIFT cycle aborts the operation immediately
    @(negedge clk);
    a = 4'b0111; b = 4'b1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    hold_diff = '0; hold_co = 1'b0; hold_ov = 1'b0;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check_hold("arst");
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check("arst_nodone", 32'(done), 32'd0);
    end
    run_op(4'b0110, 4'b0010, 1'b1);

    for (int k = 0; k < 20; k++) begin
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    // start held high: one accepted per IDLE visit
    model(4'd3, 4'd6, ed, eco, eov);
    nd = 0; first = -1; second = -1;
    @(negedge clk);
    a = 4'd3; b = 4'd6; start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 12) start = 1'b0;
      check("excl", 32'(busy & done), 32'd0);
      if (done) begin
        nd++;
        if (first < 0) first = c; else second = c;
        check("bb_diff", 32'(diff), 32'(ed));
        check("bb_co",   32'(carryout), 32'(eco));
        check("bb_ov",   32'(overflow), 32'(eov));
      end
    end
    check("bb_count",   32'(nd), 32'd2);
    check("bb_latency", 32'(first), 32'd5);
    check("bb_period",  32'(second - first), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
